// File: rtl/aq_ifu_bht_ctrl_pkg.sv
// Shared widths, FSM encoding and update-entry layout for the IFU BHT access controller.
package aq_ifu_bht_ctrl_pkg;

  localparam int unsigned BHT_IDX_W  = 10;
  localparam int unsigned BHT_DATA_W = 16;
  localparam int unsigned BHT_SEL_W  = 3;
  localparam int unsigned BHT_CNT_W  = 2;
  localparam int unsigned BHT_SLOTS  = BHT_DATA_W / BHT_CNT_W;
  localparam logic [BHT_DATA_W-1:0] BHT_INIT_VAL = 16'h5555;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INV  = 2'd1,
    ST_DONE = 2'd2
  } bht_state_e;

  typedef struct packed {
    logic [BHT_IDX_W-1:0] idx;
    logic [BHT_SEL_W-1:0] sel;
    logic [BHT_CNT_W-1:0] cnt;
  } bht_upd_t;

  // Per-bit write mask covering the selected 2-bit counter slot.
  function automatic logic [BHT_DATA_W-1:0] upd_wen(input logic [BHT_SEL_W-1:0] sel);
    return BHT_DATA_W'(2'b11) << {sel, 1'b0};
  endfunction

  // New counter value replicated into every slot; the mask picks the live one.
  function automatic logic [BHT_DATA_W-1:0] upd_din(input logic [BHT_CNT_W-1:0] cnt);
    return {BHT_SLOTS{cnt}};
  endfunction

endpackage

// File: rtl/aq_ifu_bht_upd_fifo.sv
// Two-entry buffer for BJU counter updates waiting for a free array slot.
module aq_ifu_bht_upd_fifo
  import aq_ifu_bht_ctrl_pkg::*;
(
  input  logic     forever_cpuclk,
  input  logic     cpurst_b,
  input  logic     flush,
  input  logic     push,
  input  bht_upd_t push_data,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output bht_upd_t head
);

  localparam int unsigned CNT_W = 2;

  bht_upd_t          mem [2];
  logic [CNT_W-1:0]  count;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CNT_W'(2));
  assign empty   = (count == CNT_W'(0));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
    end
  end

  // Payload storage carries no reset; count alone decides validity.
  always_ff @(posedge forever_cpuclk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/aq_ifu_bht_ctrl.sv
// Single-port BHT array arbiter: invalidate sweep, buffered counter updates and prediction reads.
module aq_ifu_bht_ctrl
  import aq_ifu_bht_ctrl_pkg::*;
#(
  parameter int unsigned           IDX_W    = BHT_IDX_W,
  parameter logic [BHT_DATA_W-1:0] INIT_VAL = BHT_INIT_VAL
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  cp0_ifu_bht_en,
  input  logic                  cp0_ifu_bht_inv,
  input  logic                  ifu_bht_rd_req,
  input  logic [IDX_W-1:0]      ifu_bht_rd_idx,
  output logic                  bht_ifu_rd_gnt,
  output logic                  bht_ifu_rd_vld,
  output logic [BHT_DATA_W-1:0] bht_ifu_rd_data,
  input  logic                  bju_bht_upd_vld,
  input  logic [IDX_W-1:0]      bju_bht_upd_idx,
  input  logic [BHT_SEL_W-1:0]  bju_bht_upd_sel,
  input  logic [BHT_CNT_W-1:0]  bju_bht_upd_cnt,
  output logic                  bht_inv_busy,
  output logic                  bht_inv_done,
  output logic                  bht_cen,
  output logic                  bht_cen_gate,
  output logic [IDX_W-1:0]      bht_idx,
  output logic [BHT_DATA_W-1:0] bht_din,
  output logic [BHT_DATA_W-1:0] bht_wen,
  input  logic [BHT_DATA_W-1:0] bht_dout
);

  bht_state_e       state;
  bht_state_e       state_nxt;
  logic [IDX_W-1:0] sweep_cnt;
  logic             sweep_last;
  logic             inv_start;
  logic             inv_act;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  bht_upd_t         fifo_head;
  bht_upd_t         upd_entry;

  assign sweep_last = &sweep_cnt;

  // FSM state register.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cp0_ifu_bht_inv) state_nxt = ST_INV;
      ST_INV:  if (sweep_last)      state_nxt = ST_DONE;
      ST_DONE:                      state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    inv_start    = 1'b0;
    inv_act      = 1'b0;
    bht_inv_busy = 1'b0;
    bht_inv_done = 1'b0;
    case (state)
      ST_IDLE: inv_start = cp0_ifu_bht_inv;
      ST_INV: begin
        inv_act      = 1'b1;
        bht_inv_busy = 1'b1;
      end
      ST_DONE: begin
        bht_inv_busy = 1'b1;
        bht_inv_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)      sweep_cnt <= '0;
    else if (inv_start) sweep_cnt <= '0;
    else if (inv_act)   sweep_cnt <= sweep_cnt + IDX_W'(1);
  end

  assign upd_entry.idx = BHT_IDX_W'(bju_bht_upd_idx);
  assign upd_entry.sel = bju_bht_upd_sel;
  assign upd_entry.cnt = bju_bht_upd_cnt;

  assign fifo_push = bju_bht_upd_vld && cp0_ifu_bht_en && (state == ST_IDLE)
                     && (!fifo_full || fifo_pop);

  aq_ifu_bht_upd_fifo u_upd_fifo (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .flush          (inv_start),
    .push           (fifo_push),
    .push_data      (upd_entry),
    .pop            (fifo_pop),
    .full           (fifo_full),
    .empty          (fifo_empty),
    .head           (fifo_head)
  );

  // Port arbitration: sweep > full drain > read > opportunistic drain.
  always_comb begin
    fifo_pop       = 1'b0;
    bht_ifu_rd_gnt = 1'b0;
    bht_cen        = 1'b0;
    bht_idx        = '0;
    bht_din        = '0;
    bht_wen        = '0;
    if (inv_act) begin
      bht_cen = 1'b1;
      bht_idx = sweep_cnt;
      bht_din = INIT_VAL;
      bht_wen = '1;
    end else if (fifo_full || (!fifo_empty && !(ifu_bht_rd_req && cp0_ifu_bht_en))) begin
      fifo_pop = 1'b1;
      bht_cen  = 1'b1;
      bht_idx  = IDX_W'(fifo_head.idx);
      bht_din  = upd_din(fifo_head.cnt);
      bht_wen  = upd_wen(fifo_head.sel);
    end else if (ifu_bht_rd_req && cp0_ifu_bht_en) begin
      bht_ifu_rd_gnt = 1'b1;
      bht_cen        = 1'b1;
      bht_idx        = ifu_bht_rd_idx;
    end
  end

  assign bht_cen_gate    = bht_cen;
  assign bht_ifu_rd_data = bht_dout;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) bht_ifu_rd_vld <= 1'b0;
    else           bht_ifu_rd_vld <= bht_ifu_rd_gnt;
  end

endmodule

// File: tb/tb_aq_ifu_bht_ctrl.sv
// Randomized bench for aq_ifu_bht_ctrl against a queue-based reference model and an array model.
module tb_aq_ifu_bht_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        en, inv, rd_req, rd_gnt, rd_vld;
  logic [9:0]  rd_idx;
  logic [15:0] rd_data;
  logic        upd_vld;
  logic [9:0]  upd_idx;
  logic [2:0]  upd_sel;
  logic [1:0]  upd_cnt;
  logic        inv_busy, inv_done, cen, cen_gate;
  logic [9:0]  idx;
  logic [15:0] din, wen, dout;

  always #5 clk = ~clk;

  aq_ifu_bht_ctrl dut (
    .forever_cpuclk  (clk),
    .cpurst_b        (rst_b),
    .cp0_ifu_bht_en  (en),
    .cp0_ifu_bht_inv (inv),
    .ifu_bht_rd_req  (rd_req),
    .ifu_bht_rd_idx  (rd_idx),
    .bht_ifu_rd_gnt  (rd_gnt),
    .bht_ifu_rd_vld  (rd_vld),
    .bht_ifu_rd_data (rd_data),
    .bju_bht_upd_vld (upd_vld),
    .bju_bht_upd_idx (upd_idx),
    .bju_bht_upd_sel (upd_sel),
    .bju_bht_upd_cnt (upd_cnt),
    .bht_inv_busy    (inv_busy),
    .bht_inv_done    (inv_done),
    .bht_cen         (cen),
    .bht_cen_gate    (cen_gate),
    .bht_idx         (idx),
    .bht_din         (din),
    .bht_wen         (wen),
    .bht_dout        (dout)
  );

  // Array model driven by the DUT's pins.
  logic [15:0] sram [1024];
  always @(posedge clk) begin
    if (cen) begin
      if (wen == 16'h0) dout <= sram[idx];
      else              sram[idx] <= (sram[idx] & ~wen) | (din & wen);
    end
  end

  // Reference model state.
  typedef struct { int idx; int sel; int cnt; } upd_s;
  upd_s        q[$];
  int          sweep_pos = -1;    // -1 idle, 0..1023 sweeping, 1024 done cycle
  logic [15:0] golden [1024];
  bit          golden_ok = 0;
  bit          prev_gnt = 0;
  bit          prev_ok = 0;
  logic [15:0] prev_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    sweep_pos = -1;
    prev_gnt  = 0;
    prev_ok   = 0;
    golden_ok = 0;
  endtask

  // Called just after a falling edge with inputs already applied; checks, advances the model, moves one cycle.
  task automatic step();
    bit          e_gnt, e_cen, popped, rd_on, idle;
    int          e_idx;
    logic [15:0] e_din, e_wen;
    logic [1:0]  c;
    upd_s        u;
    #1;
    e_gnt = 0; e_cen = 0; e_idx = 0; e_din = '0; e_wen = '0; popped = 0;
    rd_on = rd_req && en;
    if (sweep_pos >= 0 && sweep_pos < 1024) begin
      e_cen = 1; e_idx = sweep_pos; e_din = 16'h5555; e_wen = 16'hFFFF;
    end else if (q.size() == 2 || (q.size() > 0 && !rd_on)) begin
      c = 2'(q[0].cnt);
      e_cen = 1; e_idx = q[0].idx; e_din = {8{c}};
      e_wen = 16'h0003 << (2 * q[0].sel);
      popped = 1;
    end else if (rd_on) begin
      e_cen = 1; e_gnt = 1; e_idx = int'(rd_idx);
    end
    chk("rd_gnt",   32'(rd_gnt),   32'(e_gnt));
    chk("cen",      32'(cen),      32'(e_cen));
    chk("cen_gate", 32'(cen_gate), 32'(e_cen));
    chk("idx",      32'(idx),      32'(e_idx));
    chk("din",      32'(din),      32'(e_din));
    chk("wen",      32'(wen),      32'(e_wen));
    chk("inv_busy", 32'(inv_busy), 32'(sweep_pos >= 0));
    chk("inv_done", 32'(inv_done), 32'(sweep_pos == 1024));
    chk("rd_vld",   32'(rd_vld),   32'(prev_gnt));
    if (prev_gnt && prev_ok) chk("rd_data", 32'(rd_data), 32'(prev_data));

    if (e_wen != 16'h0) golden[e_idx] = (golden[e_idx] & ~e_wen) | (e_din & e_wen);
    prev_gnt = e_gnt;
    if (e_gnt) begin
      prev_data = golden[e_idx];
      prev_ok   = golden_ok;
    end
    if (popped) void'(q.pop_front());
    idle = (sweep_pos < 0);
    if (upd_vld && en && idle && q.size() < 2) begin
      u.idx = int'(upd_idx); u.sel = int'(upd_sel); u.cnt = int'(upd_cnt);
      q.push_back(u);
    end
    if (idle && inv) begin
      sweep_pos = 0;
      q.delete();
    end else if (!idle) begin
      sweep_pos++;
      if (sweep_pos == 1024) golden_ok = 1;
      if (sweep_pos == 1025) sweep_pos = -1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    en = 1'b1; inv = 1'b0; rd_req = 1'b0; rd_idx = '0;
    upd_vld = 1'b0; upd_idx = '0; upd_sel = '0; upd_cnt = '0;
  endtask

  task automatic rand_inputs(input int inv_div);
    en      = ($urandom_range(7) != 0);
    inv     = (inv_div > 0) && ($urandom_range(inv_div - 1) == 0);
    rd_req  = $urandom_range(1);
    rd_idx  = 10'($urandom);
    upd_vld = $urandom_range(1);
    upd_idx = 10'($urandom);
    upd_sel = 3'($urandom);
    upd_cnt = 2'($urandom);
  endtask

  task automatic set_upd(input logic [9:0] i, input logic [2:0] s, input logic [1:0] c);
    upd_vld = 1'b1; upd_idx = i; upd_sel = s; upd_cnt = c;
  endtask

  initial begin
    rst_b = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_busy", 32'(inv_busy), 32'd0);
    chk("rst_done", 32'(inv_done), 32'd0);
    chk("rst_vld",  32'(rd_vld),   32'd0);
    chk("rst_cen",  32'(cen),      32'd0);
    chk("rst_gnt",  32'(rd_gnt),   32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    step(); step();

    // Full invalidate sweep with reads and updates arriving throughout.
    inv = 1'b1; step();
    for (int i = 0; i < 1030; i++) begin rand_inputs(0); step(); end

    // Directed read of 0x2A5.
    idle_inputs(); rd_req = 1'b1; rd_idx = 10'h2A5; step();
    idle_inputs(); step();

    // Read and update collide with an empty FIFO: read first, write next cycle.
    idle_inputs(); rd_req = 1'b1; rd_idx = 10'd5; set_upd(10'd9, 3'd3, 2'b11);
    #1 chk("collide_gnt", 32'(rd_gnt), 32'd1);
    step();
    idle_inputs();
    #1;
    chk("collide_idx", 32'(idx), 32'd9);
    chk("collide_wen", 32'(wen), 32'h00C0);
    chk("collide_din", 32'(din), 32'hFFFF);
    step();

    // Three back-to-back updates under a continuous read stream.
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); rd_req = 1'b1; rd_idx = 10'(i);
      set_upd(10'(100 + i), 3'(i + 5), 2'(i + 1));
      step();
    end
    idle_inputs(); rd_req = 1'b1; step(); step();
    idle_inputs(); for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); rd_req = 1'b1; rd_idx = 10'(100 + i); step();
    end
    idle_inputs(); step();

    // Updates with the predictor disabled must be dropped.
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); en = 1'b0; set_upd(10'(200 + i), 3'(i), 2'b10); step();
    end
    idle_inputs(); step();

    // Mixed random traffic with occasional invalidates.
    for (int i = 0; i < 3000; i++) begin rand_inputs(1500); step(); end
    idle_inputs(); for (int i = 0; i < 1030 && sweep_pos >= 0; i++) step();

    // Reset in the middle of a sweep, then restart from index 0.
    inv = 1'b1; step();
    for (int i = 0; i < 600 && sweep_pos != 500; i++) begin rand_inputs(0); step(); end
    chk("abort_reached", 32'(sweep_pos), 32'd500);
    rst_b = 1'b0;
    #1;
    chk("abort_busy", 32'(inv_busy), 32'd0);
    chk("abort_done", 32'(inv_done), 32'd0);
    chk("abort_cen",  32'(cen),      32'd0);
    chk("abort_vld",  32'(rd_vld),   32'd0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_b = 1'b1;
    step();
    inv = 1'b1; step();
    for (int i = 0; i < 1030; i++) begin rand_inputs(0); step(); end
    for (int i = 0; i < 500; i++) begin rand_inputs(0); step(); end
    idle_inputs(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
